// File: rtl/svn_seg_scan.sv
// Multiplexed common-anode 7-segment scan controller with shadowed value load.
// Define SVN_SEG_SCAN_LZB_EN to enable leading-zero blanking.
module svn_seg_scan #(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [4*NDIG-1:0] VALUE_IN,
  input  logic              VALUE_VLD,
  output logic              VALUE_RDY,
  output logic [3:0]        D,
  output logic [NDIG-1:0]   DIG,
  output logic              FRAME
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_active;
  logic [4*NDIG-1:0] r_shadow;
  logic              r_pend;
  logic              r_rdy;
  logic [3:0]        r_d;
  logic [NDIG-1:0]   r_dig;
  logic              r_frame;

  logic              w_acc;
  logic [3:0]        w_nib;
  logic              w_cwrap;
  logic              w_iwrap;
  logic              w_lit;
`ifdef SVN_SEG_SCAN_LZB_EN
  logic [IW-1:0]     w_msd;
`endif

  always_comb begin
    w_nib = 4'h0;
    for (int k = 0; k < NDIG; k++)
      if (r_idx == IW'(k))
        w_nib = r_active[k*4 +: 4];
  end

`ifdef SVN_SEG_SCAN_LZB_EN
  // Highest nonzero digit; digit 0 when the value is all zero
  always_comb begin
    w_msd = '0;
    for (int k = 1; k < NDIG; k++)
      if (r_active[k*4 +: 4] != 4'h0)
        w_msd = IW'(k);
  end
`endif

  always_comb begin
    w_acc   = VALUE_VLD & r_rdy;
    w_cwrap = (r_cnt == CW'(PRESCALE - 1));
    w_iwrap = (r_idx == IW'(NDIG - 1));
    w_lit   = (w_nib <= 4'd9) &&
              (r_cnt >= CW'(BLANK_CYC));
`ifdef SVN_SEG_SCAN_LZB_EN
    w_lit   = w_lit && (r_idx <= w_msd);
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_active <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_rdy    <= 1'b1;
      r_d      <= 4'h0;
      r_dig    <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      // Low while pending and for the cycle after the transfer
      r_rdy   <= w_acc ? 1'b0 : !r_pend;
      if (w_acc) begin
        r_shadow <= VALUE_IN;
        r_pend   <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          r_d   <= 4'h0;
          r_dig <= '1;
          if (r_pend) begin
            r_active <= r_shadow;
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (r_cnt == '0) begin
            r_d     <= w_nib;
            r_frame <= (r_idx == '0);
          end
          r_dig <= w_lit ? ~(NDIG'(1) << r_idx) : '1;
          if (w_cwrap) begin
            r_cnt <= '0;
            if (w_iwrap) begin
              r_idx <= '0;
              if (r_pend) begin
                r_active <= r_shadow;
                r_pend   <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign VALUE_RDY = r_rdy;
  assign D         = r_d;
  assign DIG       = r_dig;
  assign FRAME     = r_frame;

endmodule

// File: tb/tb_svn_seg_scan.sv
// Bench for svn_seg_scan: frame-time reference model plus directed literal checks.
// Build with +define+SVN_SEG_SCAN_LZB_EN to exercise leading-zero blanking.
module tb_svn_seg_scan;

  localparam int P = 4;
  localparam int N = 4;
  localparam int B = 1;
  localparam int F = P * N;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [15:0] VALUE_IN = '0;
  logic        VALUE_VLD = 1'b0;
  logic        VALUE_RDY;
  logic [3:0]  D;
  logic [3:0]  DIG;
  logic        FRAME;

  int errors = 0;
  int checks = 0;

  svn_seg_scan #(.NDIG(N), .PRESCALE(P), .BLANK_CYC(B)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .VALUE_IN(VALUE_IN), .VALUE_VLD(VALUE_VLD),
    .VALUE_RDY(VALUE_RDY), .D(D), .DIG(DIG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: display time q counts cycles since scan start
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend = 0;
  bit          m_scan = 0;
  int          q = 0;
  logic [3:0]  e_d = '0;
  logic [3:0]  e_dig = 4'hF;
  logic        e_frame = 1'b0;
  logic        e_rdy = 1'b1;

  function automatic bit lit(input logic [15:0] v, input int s,
                             input int ph);
    logic [3:0] nb;
    bit r;
    nb = v[s*4 +: 4];
    r  = (ph >= B) && (nb <= 4'd9);
`ifdef SVN_SEG_SCAN_LZB_EN
    begin
      int top;
      top = 0;
      for (int k = 1; k < N; k++)
        if (v[k*4 +: 4] != 4'h0) top = k;
      r = r && (s <= top);
    end
`endif
    return r;
  endfunction

  always @(posedge CLK or negedge RST_N) begin : model
    bit acc, was;
    int s, ph;
    if (!RST_N) begin
      m_active = '0; m_shadow = '0;
      m_pend = 0; m_scan = 0; q = 0;
      e_d = '0; e_dig = 4'hF;
      e_frame = 1'b0; e_rdy = 1'b1;
    end else begin
      acc = VALUE_VLD && e_rdy;
      was = m_pend;
      if (m_scan) begin
        s       = (q / P) % N;
        ph      = q % P;
        e_d     = m_active[s*4 +: 4];
        e_frame = (q % F == 0);
        e_dig   = lit(m_active, s, ph) ? ~(4'b1 << s) : 4'hF;
        q       = q + 1;
        if (q % F == 0 && m_pend) begin
          m_active = m_shadow;
          m_pend   = 0;
        end
      end else begin
        e_d = '0; e_dig = 4'hF; e_frame = 1'b0;
        if (m_pend) begin
          m_active = m_shadow;
          m_pend   = 0;
          m_scan   = 1;
          q        = 0;
        end
      end
      e_rdy = !(acc || was);
      if (acc) begin
        m_shadow = VALUE_IN;
        m_pend   = 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("model_D", D, e_d);
    chk("model_DIG", DIG, e_dig);
    chk("model_FRAME", FRAME, e_frame);
    chk("model_RDY", VALUE_RDY, e_rdy);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    VALUE_IN  = v;
    VALUE_VLD = 1'b1;
    tick();
    VALUE_VLD = 1'b0;
  endtask

  task automatic wait_rdy;
    int n;
    n = 0;
    while (!VALUE_RDY && n < 200) begin
      tick();
      n++;
    end
    chk("rdy_timeout", VALUE_RDY, 1);
  endtask

  task automatic wait_frame;
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FRAME && n < 100);
    chk("frame_timeout", FRAME, 1);
  endtask

  // Capture one frame; sample i=0 is the FRAME cycle
  task automatic cap_check(input string nm, input logic [15:0] xd,
                           input logic [15:0] xdig);
    logic [15:0] cd, cdig, cblk;
    int s;
    wait_frame();
    for (int i = 0; i < F; i++) begin
      if (i > 0) @(negedge CLK);
      s = i / P;
      if (i % P == 0) cblk[s*4 +: 4] = DIG;
      if (i % P == 2) begin
        cd[s*4 +: 4]   = D;
        cdig[s*4 +: 4] = DIG;
      end
    end
    for (int k = 0; k < N; k++) begin
      chk({nm, "_d"}, cd[k*4 +: 4], xd[k*4 +: 4]);
      chk({nm, "_dig"}, cdig[k*4 +: 4], xdig[k*4 +: 4]);
      chk({nm, "_blank"}, cblk[k*4 +: 4], 4'hF);
    end
  endtask

  initial begin
    int nf;
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    nf = 0;
    repeat (100) begin
      tick();
      if (FRAME) nf++;
    end
    chk("idle_frames", nf, 0);
    chk("idle_dig", DIG, 4'hF);
    chk("idle_d", D, 0);
    chk("idle_rdy", VALUE_RDY, 1);

    send(16'h1234);
    chk("load_rdy_lo", VALUE_RDY, 0);
    wait_rdy();
    cap_check("v1234", 16'h1234, 16'h7BDE);
    @(negedge CLK);
    chk("frame_period", FRAME, 1);

    wait_frame();
    repeat (8) @(negedge CLK);
    VALUE_IN  = 16'h5678;
    VALUE_VLD = 1'b1;
    tick();
    VALUE_VLD = 1'b0;
    chk("mid_rdy_lo", VALUE_RDY, 0);
    @(negedge CLK);
    chk("mid_old_d", D, 4'h2);
    repeat (5) @(negedge CLK);
    chk("mid_rdy_held", VALUE_RDY, 0);
    wait_rdy();
    cap_check("v5678", 16'h5678, 16'h7BDE);

    send(16'h12A4);
    wait_rdy();
    cap_check("v12A4", 16'h12A4, 16'h7BFE);

    wait_frame();
    repeat (2) @(negedge CLK);
    chk("pre_rst_dig", DIG, 4'hE);
    repeat (8) @(negedge CLK);
    chk("slot2_dig", DIG, 4'hB);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_dig", DIG, 4'hF);
    chk("rst_d", D, 0);
    chk("rst_rdy", VALUE_RDY, 1);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    nf = 0;
    repeat (40) begin
      tick();
      if (FRAME) nf++;
    end
    chk("post_rst_frames", nf, 0);
    chk("post_rst_dig", DIG, 4'hF);

    send(16'h0042);
    wait_rdy();
`ifdef SVN_SEG_SCAN_LZB_EN
    cap_check("v0042", 16'h0042, 16'hFFDE);
`else
    cap_check("v0042", 16'h0042, 16'h7BDE);
`endif
    send(16'h0000);
    wait_rdy();
`ifdef SVN_SEG_SCAN_LZB_EN
    cap_check("v0000", 16'h0000, 16'hFFFE);
`else
    cap_check("v0000", 16'h0000, 16'h7BDE);
`endif

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
